// File: rtl/mesm6_io_bridge.sv
// rtl/mesm6_io_bridge.sv - CPU I/O request to MESM-6 peripheral register bus initiator
module mesm6_io_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [47:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [47:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_error,
  output logic        cpu_overrun,
  output logic [14:0] per_addr,
  output logic        per_read,
  output logic        per_write,
  output logic [47:0] per_wdata,
  input  logic [47:0] per_rdata,
  input  logic        per_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [1:0] S_ERR     = 2'd3;

  // Last wait cycle before the access is abandoned.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [47:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          overrun_q, overrun_d;
  logic [14:0]   addr_q, addr_d;
  logic [47:0]   wdata_q, wdata_d;
  logic          read_q, read_d;
  logic          write_q, write_d;

  logic cpu_req;

  assign cpu_req     = cpu_read | cpu_write;
  assign cpu_ready   = (state_q == S_IDLE);
  assign cpu_rdata   = rdata_q;
  assign cpu_done    = done_q;
  assign cpu_error   = error_q;
  assign cpu_overrun = overrun_q;
  assign per_addr    = addr_q;
  assign per_read    = read_q;
  assign per_write   = write_q;
  assign per_wdata   = wdata_q;

  // Next-state logic: accept, hold strobe until done or timeout, then mask one stale cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    overrun_d = overrun_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;

    // Requests arriving while busy are dropped but remembered.
    if (cpu_req && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_read ^ cpu_write) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          read_d  = cpu_read;
          write_d = cpu_write;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else if (cpu_read && cpu_write) begin
          // Ambiguous direction: report an error without touching the bus.
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_WAIT: begin
        // A done arriving on the last wait cycle still counts as success.
        if (per_done) begin
          if (read_q) begin
            rdata_d = per_rdata;
          end
          read_d  = 1'b0;
          write_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_RECOVER;
        end else if (cnt_q == CNT_LAST) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = '1;
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_RECOVER;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        // per_done here is the echo of the strobe just dropped.
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
    end
  end

endmodule

// File: tb/tb_mesm6_io_bridge.sv
// tb/tb_mesm6_io_bridge.sv - self-checking bench for mesm6_io_bridge
module tb_mesm6_io_bridge;

  localparam int T = 8;
  localparam int NCYC = T + 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic [47:0] cpu_wdata;
  logic        cpu_ready;
  logic [47:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_error;
  logic        cpu_overrun;
  logic [14:0] per_addr;
  logic        per_read;
  logic        per_write;
  logic [47:0] per_wdata;
  logic [47:0] per_rdata;
  logic        per_done;

  mesm6_io_bridge #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_error(cpu_error),
    .cpu_overrun(cpu_overrun),
    .per_addr(per_addr), .per_read(per_read), .per_write(per_write), .per_wdata(per_wdata),
    .per_rdata(per_rdata), .per_done(per_done)
  );

  always #5 clk = ~clk;

  // Responder: 16-word register file, done after resp_delay extra strobe cycles (-1 = never).
  logic [47:0] mem [16];
  int          resp_delay = 0;
  bit          hold_extra = 1'b0;
  int          rcnt = 0;
  logic        rdone_q = 1'b0;
  logic        rdone2_q = 1'b0;

  function automatic logic [47:0] def_val(int i);
    if (i == 6) return 48'h123456789ABC;
    return {8'(i), 40'h5A5A5A5A5A};
  endfunction

  assign per_rdata = mem[per_addr[3:0]];
  assign per_done  = rdone_q | (hold_extra & rdone2_q);

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= def_val(i);
      rcnt     <= 0;
      rdone_q  <= 1'b0;
      rdone2_q <= 1'b0;
    end else begin
      if (per_read | per_write) begin
        if (resp_delay >= 0 && rcnt >= resp_delay) begin
          rdone_q <= 1'b1;
          if (per_write) mem[per_addr[3:0]] <= per_wdata;
        end else begin
          rdone_q <= 1'b0;
        end
        rcnt <= rcnt + 1;
      end else begin
        rdone_q <= 1'b0;
        rcnt    <= 0;
      end
      rdone2_q <= rdone_q;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results of the most recent run().
  int          done_cyc, ndone, nstrobe, first_strobe, last_strobe, bus_bad;
  logic        err_at, rdy11;
  logic [47:0] rdata_at;

  // Drive one request in the current cycle (accepted at the next edge = edge 0),
  // then observe cycles 1..ncyc, finishing #1 after edge ncyc-1.
  task automatic run(input bit rd, input bit wr, input logic [14:0] a,
                     input logic [47:0] wd, input int ncyc);
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
    done_cyc = -1; ndone = 0; nstrobe = 0; first_strobe = -1; last_strobe = -1;
    bus_bad = 0; err_at = 1'b0; rdata_at = '0; rdy11 = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin cpu_read = 1'b0; cpu_write = 1'b0; end
      if (cpu_done) begin
        ndone++;
        if (done_cyc < 0) begin done_cyc = k; err_at = cpu_error; rdata_at = cpu_rdata; end
      end
      if (per_read | per_write) begin
        nstrobe++; last_strobe = k;
        if (first_strobe < 0) first_strobe = k;
        if (per_read !== rd || per_write !== wr || per_addr !== a || (wr && per_wdata !== wd))
          bus_bad++;
      end
      if (k == 11) rdy11 = cpu_ready;
    end
  endtask

  task automatic wait_ready();
    int budget = 20;
    while (!cpu_ready && budget > 0) begin @(posedge clk); #1; budget--; end
    chk("ready_wait", {63'd0, cpu_ready}, 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},   {63'd0, cpu_ready}, 64'd1);
    chk({tag, "_done"},    {63'd0, cpu_done}, 64'd0);
    chk({tag, "_error"},   {63'd0, cpu_error}, 64'd0);
    chk({tag, "_overrun"}, {63'd0, cpu_overrun}, 64'd0);
    chk({tag, "_rdata"},   {16'd0, cpu_rdata}, 64'd0);
    chk({tag, "_strobes"}, {62'd0, per_read, per_write}, 64'd0);
    chk({tag, "_paddr"},   {49'd0, per_addr}, 64'd0);
    chk({tag, "_pwdata"},  {16'd0, per_wdata}, 64'd0);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [14:0] addr;
    logic [47:0] wdata;
    int          dly;
    int          exp_done;
    bit          exp_err;
    logic [47:0] exp_rdata;
    int          exp_strobes;
  } vec_t;

  vec_t        tbl [8];
  logic [47:0] shadow [16];
  logic [47:0] exp_rdata;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0, 15'o6, 48'h0,            0,     3, 0, 48'h123456789ABC, 2};
    tbl[1] = '{0, 1, 15'o3, 48'hFFFF0000AAAA, 0,     3, 0, 48'h123456789ABC, 2};
    tbl[2] = '{1, 0, 15'o3, 48'h0,            0,     3, 0, 48'hFFFF0000AAAA, 2};
    tbl[3] = '{1, 0, 15'o6, 48'h0,            T - 2, T + 1, 0, 48'h123456789ABC, T};
    tbl[4] = '{1, 0, 15'o6, 48'h0,            -1,    T + 1, 1, 48'hFFFFFFFFFFFF, T};
    tbl[5] = '{1, 1, 15'o2, 48'h0,            0,     1, 1, 48'hFFFFFFFFFFFF, 0};
    tbl[6] = '{0, 1, 15'o5, 48'h0000BEEF1234, 2,     5, 0, 48'hFFFFFFFFFFFF, 4};
    tbl[7] = '{1, 0, 15'o5, 48'h0,            1,     4, 0, 48'h0000BEEF1234, 3};

    reset = 1'b0; cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven single accesses.
    for (int i = 0; i < 8; i++) begin
      resp_delay = tbl[i].dly;
      run(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, NCYC);
      chk($sformatf("t%0d_done_cycle", i), 64'(done_cyc), 64'(tbl[i].exp_done));
      chk($sformatf("t%0d_ndone", i), 64'(ndone), 64'd1);
      chk($sformatf("t%0d_error", i), {63'd0, err_at}, {63'd0, tbl[i].exp_err});
      chk($sformatf("t%0d_rdata", i), {16'd0, rdata_at}, {16'd0, tbl[i].exp_rdata});
      chk($sformatf("t%0d_nstrobe", i), 64'(nstrobe), 64'(tbl[i].exp_strobes));
      if (tbl[i].exp_strobes > 0)
        chk($sformatf("t%0d_last_strobe", i), 64'(last_strobe), 64'(tbl[i].exp_strobes));
      chk($sformatf("t%0d_bus", i), 64'(bus_bad), 64'd0);
      if (tbl[i].dly < 0)
        chk("timeout_idle_c11", {63'd0, rdy11}, 64'd1);
    end
    chk("no_overrun_yet", {63'd0, cpu_overrun}, 64'd0);

    // Write then read-back accepted at edge 4.
    resp_delay = 0;
    run(0, 1, 15'o3, 48'hFFFF0000AAAA, 4);
    chk("wr_done_cycle", 64'(done_cyc), 64'd3);
    chk("wr_bus", 64'(bus_bad), 64'd0);
    chk("wr_ready_c4", {63'd0, cpu_ready}, 64'd1);
    run(1, 0, 15'o3, 48'h0, NCYC);
    chk("rb_first_strobe", 64'(first_strobe), 64'd1);
    chk("rb_done_cycle", 64'(done_cyc), 64'd3);
    chk("rb_rdata", {16'd0, rdata_at}, 64'hFFFF0000AAAA);

    // Stale done held an extra cycle; back-to-back reads.
    hold_extra = 1'b1;
    run(1, 0, 15'o6, 48'h0, 4);
    chk("stale1_ndone", 64'(ndone), 64'd1);
    run(1, 0, 15'o3, 48'h0, NCYC);
    chk("stale2_ndone", 64'(ndone), 64'd1);
    chk("stale2_nstrobe", 64'(nstrobe), 64'd2);
    chk("stale2_done_cycle", 64'(done_cyc), 64'd3);
    hold_extra = 1'b0;

    // Overrun: a read pulse during WAIT is dropped and sticks.
    run(1, 0, 15'o6, 48'h0, 1);
    cpu_read = 1'b1; cpu_addr = 15'o3;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    chk("overrun_set", {63'd0, cpu_overrun}, 64'd1);
    @(posedge clk); #1;
    chk("overrun_orig_done", {63'd0, cpu_done}, 64'd1);
    chk("overrun_orig_rdata", {16'd0, cpu_rdata}, 64'h123456789ABC);
    run(0, 0, 15'o0, 48'h0, 6);
    chk("overrun_dropped", 64'(nstrobe + ndone), 64'd0);
    chk("overrun_sticky", {63'd0, cpu_overrun}, 64'd1);

    // Randomized accesses against an address-indexed shadow model.
    for (int i = 0; i < 16; i++) shadow[i] = def_val(i);
    shadow[3] = 48'hFFFF0000AAAA;
    shadow[5] = 48'h0000BEEF1234;
    exp_rdata = 48'h123456789ABC;
    for (int n = 0; n < 40; n++) begin
      int          kind, dsel, edone, estrb;
      bit          rd, wr, eerr;
      logic [14:0] a;
      logic [47:0] wd;
      kind = int'($urandom_range(0, 9));
      dsel = int'($urandom_range(0, 7));
      rd = (kind < 5) || (kind == 9);
      wr = (kind >= 5);
      a  = 15'($urandom);
      wd = {16'($urandom), 32'($urandom)};
      resp_delay = (dsel == 7) ? -1 : dsel;
      if (rd && wr) begin
        edone = 1; eerr = 1'b1; estrb = 0;
      end else if (dsel == 7) begin
        edone = T + 1; eerr = 1'b1; estrb = T; exp_rdata = '1;
      end else begin
        edone = dsel + 3; eerr = 1'b0; estrb = dsel + 2;
        if (rd) exp_rdata = shadow[a[3:0]];
        else    shadow[a[3:0]] = wd;
      end
      wait_ready();
      run(rd, wr, a, wd, NCYC);
      chk($sformatf("r%0d_done_cycle", n), 64'(done_cyc), 64'(edone));
      chk($sformatf("r%0d_ndone", n), 64'(ndone), 64'd1);
      chk($sformatf("r%0d_error", n), {63'd0, err_at}, {63'd0, eerr});
      chk($sformatf("r%0d_rdata", n), {16'd0, rdata_at}, {16'd0, exp_rdata});
      chk($sformatf("r%0d_nstrobe", n), 64'(nstrobe), 64'(estrb));
      chk($sformatf("r%0d_bus", n), 64'(bus_bad), 64'd0);
    end

    // Reset in cycle 2 of a read.
    resp_delay = 0;
    run(1, 0, 15'o6, 48'h0, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("midrst");
    reset = 1'b1;
    run(0, 0, 15'o0, 48'h0, 6);
    chk("midrst_no_done", 64'(ndone), 64'd0);
    run(1, 0, 15'o6, 48'h0, NCYC);
    chk("post_rst_done_cycle", 64'(done_cyc), 64'd3);
    chk("post_rst_rdata", {16'd0, rdata_at}, 64'h123456789ABC);
    chk("post_rst_error", {63'd0, err_at}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
